stage_mixer: RTL and testbench



---
 rtl/stage_mixer_pkg.sv | 23 ++
 rtl/stage_mixer_voice_scale.sv | 39 +++
 rtl/stage_mixer.sv | 86 ++++++++
 tb/tb_stage_mixer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/stage_mixer_pkg.sv
// stage_mixer_pkg: shared operator-pipeline types, sizing constants, carrier reciprocals and saturation helper.
package stage_mixer_pkg;
  localparam int NUM_VOICES = 32;
  localparam int NUM_OPERATORS = 6;
  localparam int NUM_VOICE_OPERATORS = NUM_VOICES * NUM_OPERATORS;
  localparam int SAMPLE_SHIFT = 5;
  localparam logic [2:0] LAST_OP = 3'(NUM_OPERATORS - 1);
  localparam logic [4:0] LAST_VOICE = 5'(NUM_VOICES - 1);
  typedef struct packed {
    logic [4:0] voice;
    logic [2:0] op;
  } VoiceOperatorID_t;
  typedef struct packed {
    logic       is_a_carrier;
    logic [2:0] num_carriers;
  } AlgorithmWord_t;
  // 1/n in Q16; n=1 bypasses the multiply, n=0 and n=7 are invalid and scale to zero
  localparam logic [16:0] CARRIER_RECIP [8] = '{17'd0, 17'd0, 17'd32768, 17'd21845,
                                                17'd16384, 17'd13107, 17'd10923, 17'd0};
  function automatic logic signed [15:0] sat16(input logic signed [21:0] x);
    return x > 22'sd32767 ? 16'sd32767 : x < -22'sd32768 ? -16'sd32768 : x[15:0];
  endfunction
endpackage

// File: rtl/stage_mixer_voice_scale.sv
// mixer_voice_scale: registered multiply of a voice sum by 1/NumCarriers, one cycle latency.
module mixer_voice_scale
  import stage_mixer_pkg::*;
(
  input  logic               i_Clock,
  input  logic               i_Reset_n,
  input  logic               i_Valid,
  input  logic signed [18:0] i_Sum,
  input  logic [2:0]         i_NumCarriers,
  input  logic [4:0]         i_Voice,
  output logic               o_Valid,
  output logic signed [15:0] o_Scaled,
  output logic [4:0]         o_Voice
);
  logic               valid_q, valid_d;
  logic signed [15:0] scaled_q, scaled_d;
  logic [4:0]         voice_q, voice_d;
  always_comb begin
    valid_d = i_Valid;
    voice_d = i_Valid ? i_Voice : voice_q;
    // both operands widened to 36 bits first so the product is computed at full width
    scaled_d = !i_Valid ? scaled_q :
               i_NumCarriers == 3'd1 ? i_Sum[15:0] :
               16'((36'(i_Sum) * 36'($signed({1'b0, CARRIER_RECIP[i_NumCarriers]}))) >>> 16);
  end
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) begin
      valid_q  <= 1'b0;
      scaled_q <= '0;
      voice_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      scaled_q <= scaled_d;
      voice_q  <= voice_d;
    end
  assign o_Valid  = valid_q;
  assign o_Scaled = scaled_q;
  assign o_Voice  = voice_q;
endmodule

// File: rtl/stage_mixer.sv
// stage_mixer: operator writeback, per-voice carrier sum and scaling, and frame mix to one 16-bit sample.
module stage_mixer
  import stage_mixer_pkg::*;
(
  input  logic               i_Clock,
  input  logic               i_Reset_n,
  input  logic               i_Valid,
  input  VoiceOperatorID_t   i_VoiceOperator,
  input  AlgorithmWord_t     i_AlgorithmWord,
  input  logic signed [15:0] i_Value,
  output VoiceOperatorID_t   o_OperatorWritebackID,
  output logic signed [15:0] o_OperatorWritebackValue,
  output logic signed [15:0] o_Sample,
  output logic               o_SampleValid
);
  VoiceOperatorID_t   wb_id_q, wb_id_d;
  logic signed [15:0] wb_val_q, wb_val_d;
  logic signed [18:0] voice_acc_q, voice_acc_d, sum_q, sum_d, contrib, acc_sum;
  logic               sum_valid_q, sum_valid_d, slot_ok;
  logic [2:0]         sum_num_q, sum_num_d;
  logic [4:0]         sum_voice_q, sum_voice_d, scale_voice;
  logic               scale_valid;
  logic signed [15:0] scaled;
  logic signed [21:0] frame_acc_q, frame_acc_d;
  logic               frame_done_q, frame_done_d;
  logic signed [15:0] sample_q, sample_d;
  logic               sample_valid_q, sample_valid_d;
  mixer_voice_scale u_scale (
    .i_Clock      (i_Clock),
    .i_Reset_n    (i_Reset_n),
    .i_Valid      (sum_valid_q),
    .i_Sum        (sum_q),
    .i_NumCarriers(sum_num_q),
    .i_Voice      (sum_voice_q),
    .o_Valid      (scale_valid),
    .o_Scaled     (scaled),
    .o_Voice      (scale_voice)
  );
  always_comb begin
    slot_ok = i_Valid && (i_VoiceOperator.op <= LAST_OP);
    contrib = i_AlgorithmWord.is_a_carrier ? 19'(i_Value) : 19'sd0;
    acc_sum = (i_VoiceOperator.op == 3'd0 ? 19'sd0 : voice_acc_q) + contrib;
    wb_id_d = i_Valid ? i_VoiceOperator : wb_id_q;
    wb_val_d = i_Valid ? i_Value : wb_val_q;
    voice_acc_d = slot_ok ? acc_sum : voice_acc_q;
    // the last operator's own contribution is folded into the sum handed to scaling
    sum_valid_d = slot_ok && (i_VoiceOperator.op == LAST_OP);
    sum_d = sum_valid_d ? acc_sum : sum_q;
    sum_num_d = sum_valid_d ? i_AlgorithmWord.num_carriers : sum_num_q;
    sum_voice_d = sum_valid_d ? i_VoiceOperator.voice : sum_voice_q;
    frame_acc_d = scale_valid ? (scale_voice == 5'd0 ? 22'sd0 : frame_acc_q) + 22'(scaled) : frame_acc_q;
    frame_done_d = scale_valid && (scale_voice == LAST_VOICE);
    sample_d = frame_done_q ? sat16(frame_acc_q >>> SAMPLE_SHIFT) : sample_q;
    sample_valid_d = frame_done_q;
  end
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) begin
      wb_id_q        <= '0;
      wb_val_q       <= '0;
      voice_acc_q    <= '0;
      sum_q          <= '0;
      sum_valid_q    <= 1'b0;
      sum_num_q      <= '0;
      sum_voice_q    <= '0;
      frame_acc_q    <= '0;
      frame_done_q   <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      wb_id_q        <= wb_id_d;
      wb_val_q       <= wb_val_d;
      voice_acc_q    <= voice_acc_d;
      sum_q          <= sum_d;
      sum_valid_q    <= sum_valid_d;
      sum_num_q      <= sum_num_d;
      sum_voice_q    <= sum_voice_d;
      frame_acc_q    <= frame_acc_d;
      frame_done_q   <= frame_done_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  assign o_OperatorWritebackID    = wb_id_q;
  assign o_OperatorWritebackValue = wb_val_q;
  assign o_Sample                 = sample_q;
  assign o_SampleValid            = sample_valid_q;
endmodule

// File: tb/tb_stage_mixer.sv
// tb_stage_mixer: directed frames with a queue of expected samples checked on each o_SampleValid pulse.
module tb_stage_mixer;
  import stage_mixer_pkg::*;
  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_Valid;
  VoiceOperatorID_t   i_VoiceOperator;
  AlgorithmWord_t     i_AlgorithmWord;
  logic signed [15:0] i_Value;
  VoiceOperatorID_t   o_OperatorWritebackID;
  logic signed [15:0] o_OperatorWritebackValue;
  logic signed [15:0] o_Sample;
  logic               o_SampleValid;
  int checks = 0, errors = 0, cyc = 0, last_cyc = 0;
  logic signed [31:0] exp_q [$];
  logic signed [15:0] fv [32][6];
  logic               fc [32][6];
  logic [2:0]         fn [32];
  stage_mixer dut (
    .i_Clock                 (clk),
    .i_Reset_n               (rst_n),
    .i_Valid                 (i_Valid),
    .i_VoiceOperator         (i_VoiceOperator),
    .i_AlgorithmWord         (i_AlgorithmWord),
    .i_Value                 (i_Value),
    .o_OperatorWritebackID   (o_OperatorWritebackID),
    .o_OperatorWritebackValue(o_OperatorWritebackValue),
    .o_Sample                (o_Sample),
    .o_SampleValid           (o_SampleValid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [7:0] vid, input logic car, input logic [2:0] n,
                       input logic signed [15:0] x);
    i_Valid = v;
    i_VoiceOperator = vid;
    i_AlgorithmWord = {car, n};
    i_Value = x;
    if (v && vid == 8'hFD) last_cyc = cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_frame();
    for (int v = 0; v < 32; v++) begin
      fn[v] = 3'd1;
      for (int o = 0; o < 6; o++) begin
        fv[v][o] = '0;
        fc[v][o] = 1'b0;
      end
    end
  endtask
  task automatic send_frame(input int max_gap, input int stop_slot);
    for (int v = 0; v < 32; v++)
      for (int o = 0; o < 6; o++) begin
        if (v * 6 + o == stop_slot) begin
          i_Valid = 1'b0;
          return;
        end
        repeat ($urandom_range(max_gap, 0))
          drive(1'b0, 8'($urandom), 1'($urandom), 3'($urandom), 16'($urandom));
        drive(1'b1, {5'(v), 3'(o)}, fc[v][o], fn[v], fv[v][o]);
      end
    i_Valid = 1'b0;
  endtask
  task automatic wait_sample(input string tag);
    int n = 0;
    logic signed [31:0] e;
    while (!o_SampleValid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = exp_q.pop_front();
    chk({tag, " pulse"}, 32'(o_SampleValid), 1);
    chk({tag, " latency"}, cyc - last_cyc, 4);
    chk(tag, o_Sample, e);
    @(posedge clk);
    #1;
    chk({tag, " pulse width"}, 32'(o_SampleValid), 0);
    chk({tag, " hold"}, o_Sample, e);
  endtask
  initial begin
    rst_n = 1'b0;
    i_Valid = 1'b0;
    i_VoiceOperator = '0;
    i_AlgorithmWord = '0;
    i_Value = '0;
    #1;
    chk("reset wb id", 32'(o_OperatorWritebackID), 0);
    chk("reset wb value", o_OperatorWritebackValue, 0);
    chk("reset sample", o_Sample, 0);
    chk("reset sample valid", 32'(o_SampleValid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 8'h2B, 1'b0, 3'd1, -16'sd5);
    chk("wb id", 32'(o_OperatorWritebackID), 32'h2B);
    chk("wb value", o_OperatorWritebackValue, -5);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h11, 1'b1, 3'd2, 16'sd777);
      chk("wb id hold", 32'(o_OperatorWritebackID), 32'h2B);
      chk("wb value hold", o_OperatorWritebackValue, -5);
    end
    clear_frame();
    fv[0][0] = 16'sd3200;
    fc[0][0] = 1'b1;
    exp_q.push_back(100);
    send_frame(0, 999);
    wait_sample("single carrier +");
    fv[0][0] = -16'sd3200;
    exp_q.push_back(-100);
    send_frame(0, 999);
    wait_sample("single carrier -");
    clear_frame();
    fn[3] = 3'd2;
    fv[3][0] = 16'sd4000;
    fc[3][0] = 1'b1;
    fv[3][1] = 16'sd2000;
    fc[3][1] = 1'b1;
    for (int o = 2; o < 6; o++) fv[3][o] = 16'sd30000;
    exp_q.push_back(93);
    send_frame(0, 999);
    wait_sample("two carriers");
    clear_frame();
    fn[7] = 3'd3;
    for (int o = 0; o < 6; o += 2) begin
      fv[7][o] = 16'sd30000;
      fc[7][o] = 1'b1;
    end
    exp_q.push_back(937);
    send_frame(0, 999);
    wait_sample("three carriers");
    fn[7] = 3'd0;
    exp_q.push_back(0);
    send_frame(0, 999);
    wait_sample("zero carriers");
    clear_frame();
    for (int v = 0; v < 32; v++) begin
      fv[v][0] = 16'sd32767;
      fc[v][0] = 1'b1;
    end
    exp_q.push_back(32767);
    send_frame(0, 999);
    wait_sample("full scale");
    exp_q.push_back(32767);
    send_frame(2, 999);
    wait_sample("full scale bubbles");
    send_frame(1, 12 * 6 + 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset wb id", 32'(o_OperatorWritebackID), 0);
    chk("mid reset wb value", o_OperatorWritebackValue, 0);
    chk("mid reset sample", o_Sample, 0);
    chk("mid reset sample valid", 32'(o_SampleValid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_frame();
    fv[0][0] = 16'sd3200;
    fc[0][0] = 1'b1;
    exp_q.push_back(100);
    send_frame(0, 999);
    wait_sample("after reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
